// File: rtl/signed_or_unsigned_div_if.sv
// rtl/signed_or_unsigned_div_if.sv - argument/result handshake bundle for the radix-2 divider
interface signed_or_unsigned_div_if #(
   parameter int n = 8
);
   logic         arg_vld;
   logic         arg_rdy;
   logic [n-1:0] a;
   logic [n-1:0] b;
   logic         signed_div;
   logic         res_vld;
   logic         res_rdy;
   logic [n-1:0] quo;
   logic [n-1:0] rem;
   logic         div_by_zero;

   modport master (
      output arg_vld, a, b, signed_div, res_rdy,
      input  arg_rdy, res_vld, quo, rem, div_by_zero
   );

   modport slave (
      input  arg_vld, a, b, signed_div, res_rdy,
      output arg_rdy, res_vld, quo, rem, div_by_zero
   );
endinterface

// File: rtl/signed_or_unsigned_div.sv
// rtl/signed_or_unsigned_div.sv - sequential restoring divider, signed/unsigned, optional SIGNED_OR_UNSIGNED_DIV_FAST_PATH_EN
module signed_or_unsigned_div #(
   parameter int n = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   signed_or_unsigned_div_if.slave bus
);
   localparam int CW = $clog2(n + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t         r_state;
   state_t         w_next;
   logic [n-1:0]   r_r;        // partial remainder
   logic [n-1:0]   r_q;        // dividend shifted out / quotient shifted in
   logic [n-1:0]   r_bmag;
   logic [n-1:0]   r_a;        // raw dividend, returned as remainder on divide by zero
   logic           r_qsign;
   logic           r_rsign;
   logic           r_dbz;
   logic [CW-1:0]  r_cnt;
   logic [n-1:0]   r_quo;
   logic [n-1:0]   r_rem;
   logic           r_odbz;

   logic           w_a_neg;
   logic           w_b_neg;
   logic [n-1:0]   w_amag;
   logic [n-1:0]   w_bmag;
   logic [n:0]     w_shift;
   logic           w_fit;
   logic [n-1:0]   w_diff;
   logic           w_skip;

   // Magnitudes: in n bits the magnitude of smin is its own bit pattern read unsigned.
   assign w_a_neg = bus.signed_div & bus.a[n-1];
   assign w_b_neg = bus.signed_div & bus.b[n-1];
   assign w_amag  = w_a_neg ? (~bus.a + 1'b1) : bus.a;
   assign w_bmag  = w_b_neg ? (~bus.b + 1'b1) : bus.b;

   // Trial subtraction is n+1 bits wide; the kept difference always fits back into n bits.
   assign w_shift = {r_r, r_q[n-1]};
   assign w_fit   = (w_shift >= {1'b0, r_bmag});
   assign w_diff  = w_shift[n-1:0] - r_bmag;

`ifdef SIGNED_OR_UNSIGNED_DIV_FAST_PATH_EN
   assign w_skip = (bus.b == '0) || (w_amag < w_bmag);
`else
   assign w_skip = 1'b0;
`endif

   assign bus.arg_rdy     = (r_state == IDLE);
   assign bus.res_vld     = (r_state == DONE);
   assign bus.quo         = r_quo;
   assign bus.rem         = r_rem;
   assign bus.div_by_zero = r_odbz;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (bus.arg_vld) w_next = w_skip ? FIX : CALC;
         CALC: if (r_cnt == CW'(1)) w_next = FIX;
         FIX:  w_next = DONE;
         DONE: if (bus.res_rdy) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Datapath: operand capture, one quotient bit per CALC cycle, sign fix-up into output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_r     <= '0;
         r_q     <= '0;
         r_bmag  <= '0;
         r_a     <= '0;
         r_qsign <= 1'b0;
         r_rsign <= 1'b0;
         r_dbz   <= 1'b0;
         r_cnt   <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_odbz  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.arg_vld) begin
                  r_a     <= bus.a;
                  r_bmag  <= w_bmag;
                  r_qsign <= w_a_neg ^ w_b_neg;
                  r_rsign <= w_a_neg;
                  r_dbz   <= (bus.b == '0);
                  r_cnt   <= CW'(n);
                  if (w_skip) begin
                     r_r <= w_amag;
                     r_q <= '0;
                  end else begin
                     r_r <= '0;
                     r_q <= w_amag;
                  end
               end
            end
            CALC: begin
               r_r   <= w_fit ? w_diff : w_shift[n-1:0];
               r_q   <= {r_q[n-2:0], w_fit};
               r_cnt <= r_cnt - CW'(1);
            end
            FIX: begin
               // Divide by zero bypasses sign fix-up so the all-ones quotient and raw dividend survive.
               if (r_dbz) begin
                  r_quo <= '1;
                  r_rem <= r_a;
               end else begin
                  r_quo <= r_qsign ? (~r_q + 1'b1) : r_q;
                  r_rem <= r_rsign ? (~r_r + 1'b1) : r_r;
               end
               r_odbz <= r_dbz;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_signed_or_unsigned_div.sv
// tb/tb_signed_or_unsigned_div.sv - table-driven and exhaustive scoreboard bench for the divider
module tb_signed_or_unsigned_div;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   signed_or_unsigned_div_if #(.n(N)) bus();

   signed_or_unsigned_div #(.n(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         sd;
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dz;
   } vec_t;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dz;
      int           lat;
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   function automatic int expected_latency(input logic [N-1:0] a, input logic [N-1:0] b, input logic sd);
      int lat;
      lat = N + 2;
`ifdef SIGNED_OR_UNSIGNED_DIV_FAST_PATH_EN
      begin
         int sa, sb, ma, mb;
         sa = sd ? int'($signed(a)) : int'(a);
         sb = sd ? int'($signed(b)) : int'(b);
         ma = (sa < 0) ? -sa : sa;
         mb = (sb < 0) ? -sb : sb;
         if (b == '0 || ma < mb) lat = 2;
      end
`endif
      return lat;
   endfunction

   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sd);
      exp_t e;
      int   sa, sb;
      e.dz  = (b == '0);
      e.lat = expected_latency(a, b, sd);
      if (b == '0) begin
         e.q = '1;
         e.r = a;
      end else if (!sd) begin
         e.q = a / b;
         e.r = a % b;
      end else begin
         sa = int'($signed(a));
         sb = int'($signed(b));
         if (sa == -(1 << (N - 1)) && sb == -1) begin
            e.q = a;
            e.r = '0;
         end else begin
            e.q = N'(sa / sb);
            e.r = N'(sa % sb);
         end
      end
      return e;
   endfunction

   task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sd, input exp_t e);
      int guard;
      guard = 0;
      @(negedge clk);
      bus.a          = a;
      bus.b          = b;
      bus.signed_div = sd;
      bus.arg_vld    = 1'b1;
      while (!bus.arg_rdy && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.arg_rdy) begin
         check("accept_timeout", 32'd0, 32'd1);
         bus.arg_vld = 1'b0;
      end else begin
         @(posedge clk);
         sb_q.push_back(e);
         #1 bus.arg_vld = 1'b0;
      end
   endtask

   task automatic wait_result(input string name);
      int   lat;
      exp_t e;
      lat = 1;
      while (!bus.res_vld && lat < 60) begin
         @(posedge clk);
         lat++;
         #1;
      end
      if (!bus.res_vld) begin
         check({name, "_timeout"}, 32'd0, 32'd1);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
      end else if (sb_q.size() == 0) begin
         check({name, "_unexpected"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check({name, "_quo"}, bus.quo, e.q);
         check({name, "_rem"}, bus.rem, e.r);
         check({name, "_dbz"}, bus.div_by_zero, e.dz);
         check({name, "_lat"}, lat, e.lat);
      end
   endtask

   task automatic release_result(input string name);
      bus.res_rdy = 1'b1;
      @(posedge clk);
      #1 bus.res_rdy = 1'b0;
      check({name, "_vld_drop"}, bus.res_vld, 1'b0);
      check({name, "_rdy_back"}, bus.arg_rdy, 1'b1);
   endtask

   vec_t tbl[9];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      tbl[0] = '{4'd13,    4'd3,     1'b0, 4'd4,     4'd1,     1'b0};
      tbl[1] = '{4'b1001,  4'd2,     1'b1, 4'b1101,  4'b1111,  1'b0};
      tbl[2] = '{4'd7,     4'b1110,  1'b1, 4'b1101,  4'd1,     1'b0};
      tbl[3] = '{4'b1000,  4'b1111,  1'b1, 4'b1000,  4'd0,     1'b0};
      tbl[4] = '{4'd9,     4'd0,     1'b0, 4'b1111,  4'b1001,  1'b1};
      tbl[5] = '{4'b1101,  4'd0,     1'b1, 4'b1111,  4'b1101,  1'b1};
      tbl[6] = '{4'd6,     4'd2,     1'b0, 4'd3,     4'd0,     1'b0};
      tbl[7] = '{4'd3,     4'd5,     1'b0, 4'd0,     4'd3,     1'b0};
      tbl[8] = '{4'd15,    4'd15,    1'b0, 4'd1,     4'd0,     1'b0};

      bus.arg_vld    = 1'b0;
      bus.a          = '0;
      bus.b          = '0;
      bus.signed_div = 1'b0;
      bus.res_rdy    = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset_arg_rdy", bus.arg_rdy, 1'b1);
      check("reset_res_vld", bus.res_vld, 1'b0);
      check("reset_quo", bus.quo, 4'd0);
      check("reset_rem", bus.rem, 4'd0);
      check("reset_dbz", bus.div_by_zero, 1'b0);

      for (int i = 0; i < 9; i++) begin
         e.q   = tbl[i].q;
         e.r   = tbl[i].r;
         e.dz  = tbl[i].dz;
         e.lat = expected_latency(tbl[i].a, tbl[i].b, tbl[i].sd);
         start_op(tbl[i].a, tbl[i].b, tbl[i].sd, e);
         wait_result($sformatf("tbl%0d", i));
         release_result($sformatf("tbl%0d", i));
      end

      // Backpressure: result held while res_rdy low, new arguments ignored.
      e = '{4'd4, 4'd1, 1'b0, N + 2};
      start_op(4'd13, 4'd3, 1'b0, e);
      wait_result("bp");
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            bus.a       = 4'd2;
            bus.b       = 4'd1;
            bus.arg_vld = 1'b1;
         end
         @(posedge clk);
         #1 bus.arg_vld = 1'b0;
         check($sformatf("bp_hold_quo%0d", c), bus.quo, 4'd4);
         check($sformatf("bp_hold_rem%0d", c), bus.rem, 4'd1);
         check($sformatf("bp_hold_vld%0d", c), bus.res_vld, 1'b1);
         check($sformatf("bp_hold_rdy%0d", c), bus.arg_rdy, 1'b0);
      end
      release_result("bp");
      repeat (8) begin
         @(posedge clk);
         #1 check("bp_ignored_arg", bus.res_vld, 1'b0);
      end

      // Asynchronous reset in the middle of CALC.
      start_op(4'd11, 4'd2, 1'b0, model(4'd11, 4'd2, 1'b0));
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_arg_rdy", bus.arg_rdy, 1'b1);
      check("arst_res_vld", bus.res_vld, 1'b0);
      check("arst_quo", bus.quo, 4'd0);
      check("arst_rem", bus.rem, 4'd0);
      check("arst_dbz", bus.div_by_zero, 1'b0);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      e = '{4'd3, 4'd0, 1'b0, N + 2};
      start_op(4'd6, 4'd2, 1'b0, e);
      wait_result("after_rst");
      release_result("after_rst");

      // Exhaustive sweep against the reference model.
      for (int m = 0; m < 2; m++) begin
         for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
               start_op(N'(ai), N'(bi), m[0], model(N'(ai), N'(bi), m[0]));
               wait_result($sformatf("sweep_m%0d_a%0d_b%0d", m, ai, bi));
               release_result($sformatf("sweep_m%0d_a%0d_b%0d", m, ai, bi));
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
